signal_frequency_monitor: RTL and testbench

// Receive-side checker for the forwarded oscillator path: samples a slow

---
 rtl/freq_mon_pkg.sv | 17 +
 rtl/sync_rise_detect.sv | 28 ++
 rtl/signal_frequency_monitor.sv | 123 ++++++++++++
 tb/tb_signal_frequency_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mon_pkg.sv
// Shared types and helpers for the signal frequency monitor.
package freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } freq_mon_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int unsigned n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous level into the clock domain and flags its rising edges.
// rise is combinational from the last synchroniser flop and the previous-value flop.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Synchroniser chain followed by the previous-value flop used for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/signal_frequency_monitor.sv
// Counts rising edges of a slow asynchronous signal over a fixed gate window,
// reports the count with in-range and stuck flags once per completed window.
module signal_frequency_monitor
    import freq_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned MIN_EDGES   = 120,
    parameter int unsigned MAX_EDGES   = 130,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] edge_count,
    output logic                   count_valid,
    output logic                   in_range,
    output logic                   stuck,
    output logic                   busy
);

    localparam int                     GATE_W    = clog2_min1(GATE_CYCLES);
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] MIN_T     = COUNT_WIDTH'(MIN_EDGES);
    localparam logic [COUNT_WIDTH-1:0] MAX_T     = COUNT_WIDTH'(MAX_EDGES);

    // Limits must be representable in the counter width; shifting out the
    // counter bits leaves a non-zero remainder only when they do not fit.
    if (((MIN_EDGES >> COUNT_WIDTH) != 0) || ((MAX_EDGES >> COUNT_WIDTH) != 0)) begin : g_limit_fit
        $error("MIN_EDGES/MAX_EDGES do not fit in COUNT_WIDTH bits");
    end
    if (MAX_EDGES < MIN_EDGES) begin : g_limit_order
        $error("MAX_EDGES must be >= MIN_EDGES");
    end
    if (GATE_CYCLES < 2) begin : g_gate_len
        $error("GATE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_sync_depth
        $error("SYNC_STAGES must be >= 2");
    end

    freq_mon_state_t        state;
    freq_mon_state_t        state_next;
    logic [GATE_W-1:0]      gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   rise;

    // Edge detector runs in every state so a level held through IDLE is not
    // mistaken for an edge when a window starts.
    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rise_detect (
        .clock (clock),
        .reset (reset),
        .d     (sig_in),
        .rise  (rise)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the final gate cycle wins over enable dropping so the
    // window still completes.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (enable) state_next = MEASURE;
            end
            MEASURE: begin
                if (gate_cnt == GATE_LAST) state_next = REPORT;
                else if (!enable)          state_next = IDLE;
            end
            REPORT: begin
                state_next = enable ? MEASURE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate and saturating edge counters; held at zero outside MEASURE so every
    // window starts clean, and rises seen during REPORT are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (state != MEASURE) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Result registers; they only move in REPORT, and count_valid is aligned
    // with the cycle in which the new results become visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            edge_count  <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            count_valid <= (state == REPORT);
            if (state == REPORT) begin
                edge_count <= edge_cnt;
                in_range   <= (edge_cnt >= MIN_T) && (edge_cnt <= MAX_T);
                stuck      <= (edge_cnt == '0);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_signal_frequency_monitor.sv
// Scoreboard bench for signal_frequency_monitor: two instances (default and a
// narrow-counter short-gate variant), directed stimulus, queued expectations.
module tb_signal_frequency_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        sig_a, enable_a, sig_b, enable_b;
    logic [15:0] edge_count_a;
    logic        count_valid_a, in_range_a, stuck_a, busy_a;
    logic [3:0]  edge_count_b;
    logic        count_valid_b, in_range_b, stuck_b, busy_b;

    always #5 clock = ~clock;

    signal_frequency_monitor #(
        .GATE_CYCLES (1000),
        .COUNT_WIDTH (16),
        .MIN_EDGES   (120),
        .MAX_EDGES   (130),
        .SYNC_STAGES (2)
    ) dut_a (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_a),
        .enable      (enable_a),
        .edge_count  (edge_count_a),
        .count_valid (count_valid_a),
        .in_range    (in_range_a),
        .stuck       (stuck_a),
        .busy        (busy_a)
    );

    signal_frequency_monitor #(
        .GATE_CYCLES (100),
        .COUNT_WIDTH (4),
        .MIN_EDGES   (10),
        .MAX_EDGES   (15),
        .SYNC_STAGES (2)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_b),
        .enable      (enable_b),
        .edge_count  (edge_count_b),
        .count_valid (count_valid_b),
        .in_range    (in_range_b),
        .stuck       (stuck_b),
        .busy        (busy_b)
    );

    typedef struct {
        int count;
        bit in_range;
        bit stuck;
        int tol;
        int period;
        int at_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nvalid_a = 0;
    int nvalid_b = 0;
    int last_a   = 0;
    int last_b   = 0;
    int rel      = 0;

    // Signal generator controls: half period in clocks, 0 = hold at level.
    int half_a = 4;
    int half_b = 2;
    bit hold_a = 1'b0;
    bit hold_b = 1'b0;

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        int diff;
        checks++;
        diff = (act > req) ? act - req : req - act;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (+/-%0d)", name, act, req, tol);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        check_tol(name, act, req, 0);
    endtask

    function automatic void push_a(input int c, input bit ir, input bit st,
                                   input int tol, input int per, input int at);
        exp_t e;
        e.count = c; e.in_range = ir; e.stuck = st;
        e.tol = tol; e.period = per; e.at_cyc = at;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(input int c, input bit ir, input bit st,
                                   input int tol, input int per, input int at);
        exp_t e;
        e.count = c; e.in_range = ir; e.stuck = st;
        e.tol = tol; e.period = per; e.at_cyc = at;
        q_b.push_back(e);
    endfunction

    task automatic wait_valid(input bit which_b, input int n, input int budget);
        int i;
        i = 0;
        while (((which_b ? nvalid_b : nvalid_a) < n) && (i < budget)) begin
            @(negedge clock);
            #1;
            i++;
        end
        check(which_b ? "valid_arrived_b" : "valid_arrived_a",
              int'((which_b ? nvalid_b : nvalid_a) >= n), 1);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        sig_a = 1'b0;
        forever begin
            if (half_a == 0) begin
                sig_a = hold_a;
                @(negedge clock);
            end else begin
                repeat (half_a) @(negedge clock);
                sig_a = ~sig_a;
            end
        end
    end

    initial begin
        sig_b = 1'b0;
        forever begin
            if (half_b == 0) begin
                sig_b = hold_b;
                @(negedge clock);
            end else begin
                repeat (half_b) @(negedge clock);
                sig_b = ~sig_b;
            end
        end
    end

    // Monitor A: pop an expectation for every count_valid pulse.
    always @(negedge clock) begin
        if (!reset && count_valid_a) begin
            nvalid_a++;
            if (q_a.size() == 0) begin
                check("unexpected_valid_a", 1, 0);
            end else begin
                ea = q_a.pop_front();
                check_tol("edge_count_a", int'(edge_count_a), ea.count, ea.tol);
                check("in_range_a", int'(in_range_a), int'(ea.in_range));
                check("stuck_a", int'(stuck_a), int'(ea.stuck));
                if (ea.period > 0) check("valid_period_a", cyc - last_a, ea.period);
                if (ea.at_cyc > 0) check("first_valid_cycle_a", cyc, ea.at_cyc);
            end
            last_a = cyc;
        end
    end

    // Monitor B.
    always @(negedge clock) begin
        if (!reset && count_valid_b) begin
            nvalid_b++;
            if (q_b.size() == 0) begin
                check("unexpected_valid_b", 1, 0);
            end else begin
                eb = q_b.pop_front();
                check_tol("edge_count_b", int'(edge_count_b), eb.count, eb.tol);
                check("in_range_b", int'(in_range_b), int'(eb.in_range));
                check("stuck_b", int'(stuck_b), int'(eb.stuck));
                if (eb.period > 0) check("valid_period_b", cyc - last_b, eb.period);
                if (eb.at_cyc > 0) check("first_valid_cycle_b", cyc, eb.at_cyc);
            end
            last_b = cyc;
        end
    end

    initial begin
        reset    = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_edge_count_a", int'(edge_count_a), 0);
        check("rst_count_valid_a", int'(count_valid_a), 0);
        check("rst_in_range_a", int'(in_range_a), 0);
        check("rst_stuck_a", int'(stuck_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_edge_count_b", int'(edge_count_b), 0);
        check("rst_busy_b", int'(busy_b), 0);
        enable_a = 1'b1;
        enable_b = 1'b1;
        repeat (3) @(negedge clock);
        check("busy_held_in_reset_a", int'(busy_a), 0);
        check("busy_held_in_reset_b", int'(busy_b), 0);
        enable_a = 1'b0;
        enable_b = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);

        // Period 8, three back-to-back windows: 1000/8 = 125 edges each
        push_a(125, 1'b1, 1'b0, 0, 0, 0);
        push_a(125, 1'b1, 1'b0, 0, 1001, 0);
        push_a(125, 1'b1, 1'b0, 0, 1001, 0);
        enable_a = 1'b1;
        wait_valid(1'b0, 3, 3200);

        // Abort at gate cycle 500: no report, previous results kept
        repeat (500) @(negedge clock);
        enable_a = 1'b0;
        @(negedge clock);
        #1;
        check("abort_busy_a", int'(busy_a), 0);
        check("abort_edge_count_a", int'(edge_count_a), 125);
        check("abort_in_range_a", int'(in_range_a), 1);
        check("abort_stuck_a", int'(stuck_a), 0);
        repeat (1200) @(negedge clock);
        check("abort_no_valid_a", nvalid_a, 3);
        check("abort_hold_count_a", int'(edge_count_a), 125);

        // sig held high: no edges
        half_a = 0;
        hold_a = 1'b1;
        repeat (20) @(negedge clock);
        push_a(0, 1'b0, 1'b1, 0, 0, 0);
        enable_a = 1'b1;
        wait_valid(1'b0, 4, 1100);
        enable_a = 1'b0;

        // Period 200: 1000/200 = 5 edges, below MIN
        half_a = 100;
        repeat (300) @(negedge clock);
        push_a(5, 1'b0, 1'b0, 0, 0, 0);
        enable_a = 1'b1;
        wait_valid(1'b0, 5, 1100);
        enable_a = 1'b0;

        // Reset pulsed mid-window
        half_a = 4;
        repeat (300) @(negedge clock);
        enable_a = 1'b1;
        repeat (300) @(negedge clock);
        check("busy_mid_window_a", int'(busy_a), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_edge_count_a", int'(edge_count_a), 0);
        check("async_rst_in_range_a", int'(in_range_a), 0);
        check("async_rst_stuck_a", int'(stuck_a), 0);
        check("async_rst_count_valid_a", int'(count_valid_a), 0);
        check("async_rst_busy_a", int'(busy_a), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rel = cyc;
        // One IDLE->MEASURE edge, 1000 gate cycles, one REPORT edge
        push_a(125, 1'b1, 1'b0, 1, 0, rel + 1002);
        wait_valid(1'b0, 6, 1100);
        enable_a = 1'b0;

        // Narrow counter: period 4 over 100 cycles = 25 edges, saturates at 15
        push_b(15, 1'b1, 1'b0, 0, 0, 0);
        push_b(15, 1'b1, 1'b0, 0, 101, 0);
        enable_b = 1'b1;
        wait_valid(1'b1, 2, 300);
        enable_b = 1'b0;

        repeat (10) @(negedge clock);
        check("pending_expect_a", q_a.size(), 0);
        check("pending_expect_b", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
